// File: rtl/sequence_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sequence_round_ctrl
// Purpose  : One sequence-game round: fetch a key, play it back, check presses.
//            Optional per-press input timeout: define SEQ_ROUND_CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sequence_round_ctrl #(
    parameter logic [7:0]  SHOW_TICKS          = 8'd200,
    parameter logic [7:0]  GAP_TICKS           = 8'd50,
    parameter logic [7:0]  KEY_WAIT_TICKS      = 8'd16,
    parameter logic [15:0] INPUT_TIMEOUT_TICKS = 16'd5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        start,
    input  logic [15:0] sequence_key,
    input  logic        key_valid,
    input  logic [3:0]  btn_n,
    output logic        build_req,
    output logic [3:0]  disp_nibble,
    output logic        disp_en,
    output logic        busy,
    output logic        pass,
    output logic        fail,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_SHOW  = 3'd2,
        S_GAP   = 3'd3,
        S_INPUT = 3'd4,
        S_PASS  = 3'd5,
        S_FAIL  = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_key;
    logic [15:0] r_cnt;
    logic [1:0]  r_idx;
    logic [1:0]  w_idx_next;
    logic [3:0]  r_prev_btn;
    logic        r_pass;
    logic        r_fail;
    logic        r_fault;
    logic [15:0] w_term;
    logic [16:0] w_cnt_inc;
    logic        w_expire;
    logic        w_press;
    logic [3:0]  w_nib;
    logic        w_key_load;
    logic        w_fault_set;
    logic        w_cnt_restart;

`ifndef SEQ_ROUND_CTRL_TIMEOUT_EN
    logic w_unused_timeout;
    assign w_unused_timeout = ^INPUT_TIMEOUT_TICKS;
`endif

    always_comb begin
        w_term = 16'd0;
        case (r_state)
            S_REQ:   w_term = {8'd0, KEY_WAIT_TICKS};
            S_SHOW:  w_term = {8'd0, SHOW_TICKS};
            S_GAP:   w_term = {8'd0, GAP_TICKS};
`ifdef SEQ_ROUND_CTRL_TIMEOUT_EN
            S_INPUT: w_term = INPUT_TIMEOUT_TICKS;
`endif
            default: w_term = 16'd0;
        endcase
    end

    // A terminal count of 0 behaves like 1: the state ends on its first tick.
    assign w_cnt_inc = {1'b0, r_cnt} + 17'd1;
    assign w_expire  = tick && (w_cnt_inc >= {1'b0, w_term});
    assign w_press   = (r_prev_btn == 4'hF) && (btn_n != 4'hF);

    always_comb begin
        w_nib = r_key[15:12];
        case (r_idx)
            2'd1:    w_nib = r_key[11:8];
            2'd2:    w_nib = r_key[7:4];
            2'd3:    w_nib = r_key[3:0];
            default: w_nib = r_key[15:12];
        endcase
    end

    always_comb begin
        w_next        = r_state;
        w_idx_next    = r_idx;
        w_key_load    = 1'b0;
        w_fault_set   = 1'b0;
        w_cnt_restart = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_next = S_REQ;
            S_REQ: begin
                if (key_valid) begin
                    w_key_load = 1'b1;
                    w_idx_next = 2'd0;
                    w_next     = S_SHOW;
                end else if (w_expire) begin
                    w_fault_set = 1'b1;
                    w_next      = S_IDLE;
                end
            end
            S_SHOW: if (w_expire) w_next = S_GAP;
            S_GAP: begin
                if (w_expire) begin
                    if (r_idx == 2'd3) begin
                        w_idx_next = 2'd0;
                        w_next     = S_INPUT;
                    end else begin
                        w_idx_next = r_idx + 2'd1;
                        w_next     = S_SHOW;
                    end
                end
            end
            S_INPUT: begin
                if (w_press) begin
                    if (btn_n != w_nib) begin
                        w_next = S_FAIL;
                    end else if (r_idx == 2'd3) begin
                        w_next = S_PASS;
                    end else begin
                        w_idx_next    = r_idx + 2'd1;
                        w_cnt_restart = 1'b1;
                    end
                end
`ifdef SEQ_ROUND_CTRL_TIMEOUT_EN
                else if (w_expire) begin
                    w_next = S_FAIL;
                end
`endif
            end
            S_PASS:  w_next = S_IDLE;
            S_FAIL:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_key      <= 16'h0;
            r_cnt      <= 16'd0;
            r_idx      <= 2'd0;
            r_prev_btn <= 4'hF;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_idx      <= w_idx_next;
            r_prev_btn <= btn_n;
            if (w_key_load) r_key <= sequence_key;
            if ((w_next != r_state) || w_cnt_restart) begin
                r_cnt <= 16'd0;
            end else if (tick) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_fault_set) r_fault <= 1'b1;
            // Pulses are registered so the game FSM sees glitch-free strobes.
            r_pass <= (r_state == S_PASS);
            r_fail <= (r_state == S_FAIL) || w_fault_set;
        end
    end

    assign build_req   = (r_state == S_REQ);
    assign disp_en     = (r_state == S_SHOW);
    assign disp_nibble = disp_en ? w_nib : 4'hF;
    assign busy        = (r_state != S_IDLE);
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign fault       = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_sequence_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sequence_round_ctrl
// Purpose  : Self-checking bench: vector table, corner sequences, random rounds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequence_round_ctrl;

    localparam logic [7:0]  c_show_ticks = 8'd4;
    localparam logic [7:0]  c_gap_ticks  = 8'd2;
    localparam logic [7:0]  c_wait_ticks = 8'd16;
    localparam logic [15:0] c_tmo_ticks  = 16'd10;
`ifdef SEQ_ROUND_CTRL_TIMEOUT_EN
    localparam int c_hold_long = 20;
`else
    localparam int c_hold_long = 100;
`endif

    logic        clk;
    logic        rst;
    logic        tick;
    logic        start;
    logic [15:0] sequence_key;
    logic        key_valid;
    logic [3:0]  btn_n;
    logic        build_req;
    logic [3:0]  disp_nibble;
    logic        disp_en;
    logic        busy;
    logic        pass;
    logic        fail;
    logic        fault;

    sequence_round_ctrl #(
        .SHOW_TICKS          (c_show_ticks),
        .GAP_TICKS           (c_gap_ticks),
        .KEY_WAIT_TICKS      (c_wait_ticks),
        .INPUT_TIMEOUT_TICKS (c_tmo_ticks)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick         (tick),
        .start        (start),
        .sequence_key (sequence_key),
        .key_valid    (key_valid),
        .btn_n        (btn_n),
        .build_req    (build_req),
        .disp_nibble  (disp_nibble),
        .disp_en      (disp_en),
        .busy         (busy),
        .pass         (pass),
        .fail         (fail),
        .fault        (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int tick_ph  = 0;

    // Observations gathered mid-cycle
    int         req_ticks, show_ticks, gap_ticks;
    int         pass_cnt = 0, fail_cnt = 0, both_cnt = 0;
    int         nib_glitch, blank_bad, pass_cyc;
    bit         prev_en = 1'b0;
    logic [3:0] shown_q[$];
    int         len_q[$];
    int         gap_q[$];

    initial begin
        forever begin
            @(negedge clk);
            if (build_req && tick) req_ticks++;
            if (disp_en) begin
                if (!prev_en) begin
                    shown_q.push_back(disp_nibble);
                    if (shown_q.size() > 1) gap_q.push_back(gap_ticks);
                    show_ticks = 0;
                end
                if (disp_nibble !== shown_q[$]) nib_glitch++;
                if (tick) show_ticks++;
            end else begin
                if (prev_en) begin
                    len_q.push_back(show_ticks);
                    gap_ticks = 0;
                end
                if (tick) gap_ticks++;
                if (disp_nibble !== 4'hF) blank_bad++;
            end
            if (pass === 1'b1) begin
                pass_cnt++;
                pass_cyc = cyc;
            end
            if (fail === 1'b1) fail_cnt++;
            if (pass === 1'b1 && fail === 1'b1) both_cnt++;
            prev_en = (disp_en === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick_ph = (tick_ph == 2) ? 0 : tick_ph + 1;
        tick    = (tick_ph == 0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        req_ticks  = 0;
        nib_glitch = 0;
        blank_bad  = 0;
        pass_cyc   = -1;
        shown_q.delete();
        len_q.delete();
        gap_q.delete();
    endtask

    function automatic logic [3:0] nib(input logic [15:0] v, input int i);
        logic [15:0] t;
        t = v >> (12 - 4 * i);
        return t[3:0];
    endfunction

    function automatic logic [3:0] pick_btn(input int s);
        case (s)
            0:       return 4'hE;
            1:       return 4'hD;
            2:       return 4'hB;
            default: return 4'h7;
        endcase
    endfunction

    // Round outcome from the game rules: every press must equal its key nibble.
    function automatic bit model_pass(input logic [15:0] key, input logic [15:0] pr);
        for (int i = 0; i < 4; i++)
            if (nib(key, i) != nib(pr, i)) return 1'b0;
        return 1'b1;
    endfunction

    // Plays the builder: answers key_valid once 'delay' ticks have been seen.
    task automatic answer_req(input logic [15:0] key, input int delay, input bit kv_tick);
        int cnt;
        int g;
        cnt = 0;
        g   = 0;
        while (build_req && g < 1000) begin
            if (cnt == delay && (kv_tick ? tick : !tick)) begin
                key_valid    = 1'b1;
                sequence_key = key;
            end else begin
                key_valid    = 1'b0;
                sequence_key = 16'($urandom);
                if (tick) cnt++;
            end
            step();
            g++;
        end
        key_valid = 1'b0;
    endtask

    task automatic run_round(input string name, input logic [15:0] key, input int delay,
                             input bit kv_tick, input bit do_press, input logic [15:0] presses,
                             input int hold, input bit exp_pass, input bit exp_fault);
        int g, pc0, fc0, last_cyc, exp_req;
        bit tmo;
        tmo     = kv_tick ? (delay + 1 > int'(c_wait_ticks)) : (delay >= int'(c_wait_ticks));
        exp_req = tmo ? int'(c_wait_ticks) : delay + int'(kv_tick);
        clear_mon();
        pc0      = pass_cnt;
        fc0      = fail_cnt;
        last_cyc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({name, ":start_to_build_req"}, build_req, 1);
        answer_req(key, delay, kv_tick);
        if (!tmo) begin
            g = 0;
            while (len_q.size() < 4 && g < 2000) begin
                step();
                g++;
            end
            repeat (3 * int'(c_gap_ticks) + 3) step();
            if (do_press) begin
                for (int i = 0; i < 4; i++) begin
                    btn_n    = nib(presses, i);
                    last_cyc = cyc;
                    repeat ((i == 0) ? hold : 1 + (i % 2)) step();
                    btn_n = 4'hF;
                    repeat (2) step();
                end
            end
        end
        g = 0;
        while (busy && g < 3000) begin
            step();
            g++;
        end
        repeat (2) step();
        chk({name, ":busy_idle"}, busy, 0);
        chk({name, ":pass_pulses"}, pass_cnt - pc0, exp_pass ? 1 : 0);
        chk({name, ":fail_pulses"}, fail_cnt - fc0, exp_pass ? 0 : 1);
        chk({name, ":fault"}, fault, exp_fault);
        chk({name, ":req_ticks"}, req_ticks, exp_req);
        chk({name, ":pass_and_fail"}, both_cnt, 0);
        if (tmo) begin
            chk({name, ":no_display"}, shown_q.size(), 0);
        end else begin
            chk({name, ":shown_count"}, shown_q.size(), 4);
            chk({name, ":gap_count"}, gap_q.size(), 3);
            for (int i = 0; i < 4; i++) begin
                if (i < shown_q.size()) chk($sformatf("%s:nibble%0d", name, i), shown_q[i], nib(key, i));
                if (i < len_q.size())   chk($sformatf("%s:show_len%0d", name, i), len_q[i], c_show_ticks);
                if (i < gap_q.size())   chk($sformatf("%s:gap_len%0d", name, i), gap_q[i], c_gap_ticks);
            end
            chk({name, ":steady_nibble"}, nib_glitch, 0);
            chk({name, ":blank_is_F"}, blank_bad, 0);
        end
        if (exp_pass) chk({name, ":pass_latency"}, pass_cyc - last_cyc, 2);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, ":build_req"}, build_req, 0);
        chk({name, ":disp_nibble"}, disp_nibble, 4'hF);
        chk({name, ":disp_en"}, disp_en, 0);
        chk({name, ":busy"}, busy, 0);
        chk({name, ":pass"}, pass, 0);
        chk({name, ":fail"}, fail, 0);
        chk({name, ":fault"}, fault, 0);
    endtask

    typedef struct {
        logic [15:0] key;
        int          delay;
        logic [15:0] presses;
        int          hold;
        bit          exp_pass;
    } vec_t;

    vec_t        tbl[7];
    logic [15:0] rk, rp;
    int          rd;
    bit          rexp, rfault;
    int          g;

    initial begin
        tbl[0] = '{16'hE7BD, 3,  16'hE7BD, 1,           1'b1};
        tbl[1] = '{16'hE7BD, 3,  16'hEBBD, 1,           1'b0};
        tbl[2] = '{16'hE7BD, 3,  16'hE7BD, c_hold_long, 1'b1};
        tbl[3] = '{16'hDBE7, 5,  16'hDBE7, 2,           1'b1};
        tbl[4] = '{16'h7777, 1,  16'h777E, 1,           1'b0};
        tbl[5] = '{16'hBDE7, 7,  16'hBCE7, 1,           1'b0};
        tbl[6] = '{16'hE7BD, 15, 16'hE7BD, 1,           1'b1};

        rst          = 1'b0;
        tick         = 1'b0;
        start        = 1'b0;
        key_valid    = 1'b0;
        sequence_key = 16'h0;
        btn_n        = 4'hF;
        clear_mon();
        repeat (3) step();
        chk_reset_outputs("reset");
        rst = 1'b1;
        step();

        for (int t = 0; t < 7; t++)
            run_round($sformatf("tbl%0d", t), tbl[t].key, tbl[t].delay, 1'b0, 1'b1,
                      tbl[t].presses, tbl[t].hold, tbl[t].exp_pass, 1'b0);

        // key_valid lands on the very tick that would time out the builder
        run_round("kv_on_last_tick", 16'hB7ED, int'(c_wait_ticks) - 1, 1'b1, 1'b1,
                  16'hB7ED, 1, 1'b1, 1'b0);

        run_round("key_timeout", 16'hE7BD, 40, 1'b0, 1'b1, 16'hE7BD, 1, 1'b0, 1'b1);
        run_round("fault_sticky", 16'hE7BD, 3, 1'b0, 1'b1, 16'hE7BD, 1, 1'b1, 1'b1);

        // Reset while showing the third nibble, then replay from nibble 0
        clear_mon();
        start = 1'b1;
        step();
        start = 1'b0;
        answer_req(16'hE7BD, 2, 1'b0);
        g = 0;
        while (shown_q.size() < 3 && g < 2000) begin
            step();
            g++;
        end
        chk("mid_show:nibble2", disp_nibble, 4'hB);
        rst = 1'b0;
        step();
        chk_reset_outputs("mid_show_reset");
        rst = 1'b1;
        step();
        run_round("replay", 16'hE7BD, 2, 1'b0, 1'b1, 16'hE7BD, 1, 1'b1, 1'b0);

`ifdef SEQ_ROUND_CTRL_TIMEOUT_EN
        run_round("input_timeout", 16'hE7BD, 3, 1'b0, 1'b0, 16'hFFFF, 1, 1'b0, 1'b0);
`endif

        rfault = 1'b0;
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 4; i++) begin
                rk = {rk[11:0], pick_btn(int'($urandom_range(0, 3)))};
                rp = {rp[11:0], ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : rk[3:0]};
            end
            rd     = int'($urandom_range(1, 18));
            rexp   = model_pass(rk, rp) && (rd < int'(c_wait_ticks));
            rfault = rfault || (rd >= int'(c_wait_ticks));
            run_round($sformatf("rand%0d", r), rk, rd, 1'b0, 1'b1, rp,
                      int'($urandom_range(1, 5)), rexp, rfault);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
